// File: rtl/alu_issue_seq.sv
// alu_issue_seq: initiator side of the combinational ALU.
// Drives A/B/Op, waits a settle window, then retires to WB, HI/LO or flags.
module alu_issue_seq #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2,
    parameter int DST_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [DST_W-1:0] req_dst,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic [WIDTH-1:0] alu_low,
    input  logic [WIDTH-1:0] alu_status,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [DST_W-1:0] wb_dst,
    output logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic [3:0]       flags_q,
    output logic             busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [DST_W-1:0] dst_q, dst_d;
    logic             wb_valid_q, wb_valid_d;
    logic [DST_W-1:0] wb_dst_q, wb_dst_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [3:0]       flags_d;
    logic [3:0]       status_flags;

    // Only the top four status bits carry flags; the rest are ignored.
    logic unused_status;
    assign unused_status = ^alu_status[WIDTH-5:0];
    assign status_flags  = alu_status[WIDTH-1 -: 4];

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign wb_valid  = wb_valid_q;
    assign wb_dst    = wb_dst_q;
    assign wb_data   = wb_data_q;

    // Next-state and datapath selection for the issue sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        dst_d      = dst_q;
        wb_valid_d = wb_valid_q;
        wb_dst_d   = wb_dst_q;
        wb_data_d  = wb_data_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        flags_d    = flags_q;
        unique case (state_q)
            S_IDLE: begin
                alu_op_d = OP_CLR;
                if (req_valid) begin
                    alu_a_d  = req_a;
                    alu_b_d  = req_b;
                    alu_op_d = req_op;
                    dst_d    = req_dst;
                    cnt_d    = CNT_INIT;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                unique case (alu_op_q)
                    OP_MUL: begin
                        hi_d     = alu_hi;
                        lo_d     = alu_low;
                        alu_op_d = OP_CLR;
                        state_d  = S_IDLE;
                    end
                    OP_CMP: begin
                        flags_d  = status_flags;
                        alu_op_d = OP_CLR;
                        state_d  = S_IDLE;
                    end
                    OP_ADD, OP_SUB: begin
                        flags_d    = status_flags;
                        wb_data_d  = alu_result;
                        wb_dst_d   = dst_q;
                        wb_valid_d = 1'b1;
                        state_d    = S_WB;
                    end
                    default: begin
                        wb_data_d  = alu_result;
                        wb_dst_d   = dst_q;
                        wb_valid_d = 1'b1;
                        state_d    = S_WB;
                    end
                endcase
            end
            S_WB: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    alu_op_d   = OP_CLR;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= OP_CLR;
            dst_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_dst_q   <= '0;
            wb_data_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            flags_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            dst_q      <= dst_d;
            wb_valid_q <= wb_valid_d;
            wb_dst_q   <= wb_dst_d;
            wb_data_q  <= wb_data_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            flags_q    <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed vectors plus multi-cycle corner sequences.
// A stub combinational ALU answers both DUT instances.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [15:0] req_a = 16'd0;
    logic [15:0] req_b = 16'd0;
    logic [2:0]  req_dst = 3'd0;
    logic [15:0] stub_status = 16'd0;

    logic        req_valid0 = 1'b0, wb_ready0 = 1'b1;
    logic        req_ready0, wb_valid0, busy0;
    logic [15:0] alu_a0, alu_b0, alu_res0, alu_hi0, alu_low0;
    logic [2:0]  alu_op0, wb_dst0;
    logic [15:0] wb_data0, hi0, lo0;
    logic [3:0]  flags0;

    logic        req_valid1 = 1'b0, wb_ready1 = 1'b1;
    logic        req_ready1, wb_valid1, busy1;
    logic [15:0] alu_a1, alu_b1, alu_res1, alu_hi1, alu_low1;
    logic [2:0]  alu_op1, wb_dst1;
    logic [15:0] wb_data1, hi1, lo1;
    logic [3:0]  flags1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] stub_res(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [2:0] op);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            3'd0: return 16'd0;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a & b;
            3'd4: return b;
            3'd5: return a << 1;
            3'd6: return p[15:0];
            default: return a - b;
        endcase
    endfunction

    assign alu_res0 = stub_res(alu_a0, alu_b0, alu_op0);
    assign {alu_hi0, alu_low0} = 32'(alu_a0) * 32'(alu_b0);
    assign alu_res1 = stub_res(alu_a1, alu_b1, alu_op1);
    assign {alu_hi1, alu_low1} = 32'(alu_a1) * 32'(alu_b1);

    alu_issue_seq #(.WIDTH(16), .SETTLE(2), .DST_W(3)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0),
        .alu_result(alu_res0), .alu_hi(alu_hi0), .alu_low(alu_low0),
        .alu_status(stub_status),
        .wb_valid(wb_valid0), .wb_ready(wb_ready0),
        .wb_dst(wb_dst0), .wb_data(wb_data0),
        .hi_q(hi0), .lo_q(lo0), .flags_q(flags0), .busy(busy0)
    );

    alu_issue_seq #(.WIDTH(16), .SETTLE(1), .DST_W(3)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .alu_result(alu_res1), .alu_hi(alu_hi1), .alu_low(alu_low1),
        .alu_status(stub_status),
        .wb_valid(wb_valid1), .wb_ready(wb_ready1),
        .wb_dst(wb_dst1), .wb_data(wb_data1),
        .hi_q(hi1), .lo_q(lo1), .flags_q(flags1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dst;
        logic [15:0] status;
        logic        exp_wb;
        logic [15:0] exp_data;
        logic [3:0]  exp_flags;
        logic [15:0] exp_hi;
        logic [15:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        logic seen;

        vecs[0] = '{3'd1, 16'h0003, 16'h0004, 3'd2, 16'h2000,
                    1'b1, 16'h0007, 4'h2, 16'h0000, 16'h0000};
        vecs[1] = '{3'd6, 16'h1234, 16'h0100, 3'd5, 16'hF000,
                    1'b0, 16'h0000, 4'h2, 16'h0012, 16'h3400};
        vecs[2] = '{3'd7, 16'h0005, 16'h0005, 3'd0, 16'h8000,
                    1'b0, 16'h0000, 4'h8, 16'h0012, 16'h3400};
        vecs[3] = '{3'd3, 16'h00F0, 16'h0FF0, 3'd3, 16'h4000,
                    1'b1, 16'h00F0, 4'h8, 16'h0012, 16'h3400};
        vecs[4] = '{3'd4, 16'h1111, 16'hABCD, 3'd7, 16'h1000,
                    1'b1, 16'hABCD, 4'h8, 16'h0012, 16'h3400};
        vecs[5] = '{3'd5, 16'h8001, 16'h0000, 3'd1, 16'h0000,
                    1'b1, 16'h0002, 4'h8, 16'h0012, 16'h3400};
        vecs[6] = '{3'd2, 16'h0005, 16'h0007, 3'd4, 16'h6000,
                    1'b1, 16'hFFFE, 4'h6, 16'h0012, 16'h3400};
        vecs[7] = '{3'd0, 16'h5555, 16'h3333, 3'd6, 16'hF000,
                    1'b1, 16'h0000, 4'h6, 16'h0012, 16'h3400};

        // Reset state
        #3;
        chk("rst_ready", req_ready0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_wb_valid", wb_valid0, 0);
        chk("rst_alu_op", alu_op0, 0);
        chk("rst_flags", flags0, 0);
        #4 rst_n = 1'b1;
        step;

        // Table of single operations, SETTLE=2, wb_ready high
        for (int i = 0; i < 8; i++) begin
            req_op = vecs[i].op;
            req_a = vecs[i].a;
            req_b = vecs[i].b;
            req_dst = vecs[i].dst;
            stub_status = vecs[i].status;
            wb_ready0 = 1'b1;
            req_valid0 = 1'b1;
            chk($sformatf("v%0d_ready", i), req_ready0, 1);
            step;
            req_valid0 = 1'b0;
            chk($sformatf("v%0d_busy", i), busy0, 1);
            chk($sformatf("v%0d_alu_a", i), alu_a0, vecs[i].a);
            chk($sformatf("v%0d_alu_op", i), alu_op0, vecs[i].op);
            lat = 0;
            seen = 1'b0;
            while (lat < 20) begin
                step;
                lat++;
                if (wb_valid0) begin
                    seen = 1'b1;
                    break;
                end
                if (req_ready0) break;
            end
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_wb_seen", i), seen, vecs[i].exp_wb);
            if (seen) begin
                chk($sformatf("v%0d_wb_data", i), wb_data0, vecs[i].exp_data);
                chk($sformatf("v%0d_wb_dst", i), wb_dst0, vecs[i].dst);
                step;
                chk($sformatf("v%0d_wb_pulse", i), wb_valid0, 0);
            end
            chk($sformatf("v%0d_idle", i), req_ready0, 1);
            chk($sformatf("v%0d_op_clr", i), alu_op0, 0);
            chk($sformatf("v%0d_flags", i), flags0, vecs[i].exp_flags);
            chk($sformatf("v%0d_hi", i), hi0, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo0, vecs[i].exp_lo);
        end

        // SUB with writeback stalled; a second request waits
        req_op = 3'd2; req_a = 16'h0009; req_b = 16'h0002; req_dst = 3'd4;
        stub_status = 16'h4000;
        wb_ready0 = 1'b0;
        req_valid0 = 1'b1;
        step;
        req_op = 3'd1; req_a = 16'h0001; req_b = 16'h0001; req_dst = 3'd1;
        step; step; step;
        chk("stall_wb_valid", wb_valid0, 1);
        chk("stall_wb_data", wb_data0, 16'h0007);
        chk("stall_wb_dst", wb_dst0, 4);
        chk("stall_flags", flags0, 4'h4);
        for (int k = 0; k < 5; k++) begin
            step;
            chk($sformatf("stall%0d_valid", k), wb_valid0, 1);
            chk($sformatf("stall%0d_data", k), wb_data0, 16'h0007);
            chk($sformatf("stall%0d_dst", k), wb_dst0, 4);
            chk($sformatf("stall%0d_ready", k), req_ready0, 0);
        end
        wb_ready0 = 1'b1;
        step;
        chk("release_wb_valid", wb_valid0, 0);
        chk("release_not_taken", busy0, 0);
        step;
        chk("second_taken", busy0, 1);
        chk("second_alu_a", alu_a0, 16'h0001);
        req_valid0 = 1'b0;
        lat = 0;
        while (lat < 20 && !wb_valid0) begin
            step;
            lat++;
        end
        chk("second_latency", lat, 3);
        chk("second_wb_data", wb_data0, 16'h0002);
        chk("second_wb_dst", wb_dst0, 1);
        step;

        // Reset during DRIVE of a MUL
        req_op = 3'd6; req_a = 16'h1234; req_b = 16'h0100; req_dst = 3'd2;
        req_valid0 = 1'b1;
        step;
        req_valid0 = 1'b0;
        step;
        chk("mid_busy", busy0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_alu_a", alu_a0, 0);
        chk("arst_alu_b", alu_b0, 0);
        chk("arst_alu_op", alu_op0, 0);
        chk("arst_hi", hi0, 0);
        chk("arst_lo", lo0, 0);
        chk("arst_flags", flags0, 0);
        chk("arst_wb", {wb_valid0, wb_dst0, wb_data0}, 0);
        #2 rst_n = 1'b1;
        step; step; step; step;
        chk("post_rst_hi", hi0, 0);
        chk("post_rst_lo", lo0, 0);
        chk("post_rst_busy", busy0, 0);

        // SETTLE=1 instance: operands held, sample on 2nd edge
        req_op = 3'd1; req_a = 16'h0010; req_b = 16'h0020; req_dst = 3'd6;
        wb_ready1 = 1'b1;
        req_valid1 = 1'b1;
        step;
        req_valid1 = 1'b0;
        req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = 3'd3;
        chk("s1_alu_a0", alu_a1, 16'h0010);
        chk("s1_alu_b0", alu_b1, 16'h0020);
        chk("s1_alu_op0", alu_op1, 1);
        chk("s1_no_wb_e0", wb_valid1, 0);
        step;
        chk("s1_alu_a1", alu_a1, 16'h0010);
        chk("s1_alu_b1", alu_b1, 16'h0020);
        chk("s1_alu_op1", alu_op1, 1);
        chk("s1_no_wb_e1", wb_valid1, 0);
        step;
        chk("s1_wb_e2", wb_valid1, 1);
        chk("s1_wb_data", wb_data1, 16'h0030);
        chk("s1_wb_dst", wb_dst1, 6);
        step;
        chk("s1_idle", req_ready1, 1);
        chk("s1_op_clr", alu_op1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
